max7219_receiver: RTL



---
 rtl/max7219_receiver_pkg.sv | 66 ++++++
 rtl/max7219_receiver_if.sv | 31 +++
 rtl/max7219_receiver_codeb.sv | 18 +
 rtl/max7219_receiver.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/max7219_receiver_pkg.sv
// ---------------------------------------------------------------------------
// max7219_pkg
// Shared definitions for the MAX7219 emulation:
//   - register address map (also used by the ledmatrix controller)
//   - receiver state encoding
//   - Code-B segment patterns and the digit-to-pattern lookup
// Segment bit order is {A,B,C,D,E,F,G}; DP is added by the caller.
// ---------------------------------------------------------------------------
package max7219_pkg;

   localparam logic [3:0] ADDR_NOOP      = 4'h0;
   localparam logic [3:0] ADDR_DIGIT_LO  = 4'h1;
   localparam logic [3:0] ADDR_DIGIT_HI  = 4'h8;
   localparam logic [3:0] ADDR_DECODE    = 4'h9;
   localparam logic [3:0] ADDR_INTENSITY = 4'hA;
   localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
   localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
   localparam logic [3:0] ADDR_TEST      = 4'hF;

   typedef enum logic [1:0] {
      Idle,
      Shift,
      Apply
   } t_rx_state;

   localparam logic [6:0] CODEB_0     = 7'b1111110;
   localparam logic [6:0] CODEB_1     = 7'b0110000;
   localparam logic [6:0] CODEB_2     = 7'b1101101;
   localparam logic [6:0] CODEB_3     = 7'b1111001;
   localparam logic [6:0] CODEB_4     = 7'b0110011;
   localparam logic [6:0] CODEB_5     = 7'b1011011;
   localparam logic [6:0] CODEB_6     = 7'b1011111;
   localparam logic [6:0] CODEB_7     = 7'b1110000;
   localparam logic [6:0] CODEB_8     = 7'b1111111;
   localparam logic [6:0] CODEB_9     = 7'b1111011;
   localparam logic [6:0] CODEB_DASH  = 7'b0000001;
   localparam logic [6:0] CODEB_E     = 7'b1001111;
   localparam logic [6:0] CODEB_H     = 7'b0110111;
   localparam logic [6:0] CODEB_L     = 7'b0001110;
   localparam logic [6:0] CODEB_P     = 7'b1100111;
   localparam logic [6:0] CODEB_BLANK = 7'b0000000;

   function automatic logic [6:0] codeb_segs(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0:    s = CODEB_0;
         4'h1:    s = CODEB_1;
         4'h2:    s = CODEB_2;
         4'h3:    s = CODEB_3;
         4'h4:    s = CODEB_4;
         4'h5:    s = CODEB_5;
         4'h6:    s = CODEB_6;
         4'h7:    s = CODEB_7;
         4'h8:    s = CODEB_8;
         4'h9:    s = CODEB_9;
         4'hA:    s = CODEB_DASH;
         4'hB:    s = CODEB_E;
         4'hC:    s = CODEB_H;
         4'hD:    s = CODEB_L;
         4'hE:    s = CODEB_P;
         default: s = CODEB_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/max7219_receiver_if.sv
// ---------------------------------------------------------------------------
// max7219_receiver_if
// 3-wire MAX7219 serial bus plus the daisy-chain return line.
//   in_sclk  : serial clock (data sampled on rising edge)
//   in_cs    : LOAD/CS, active low, word latched on rising edge
//   in_din   : serial data, MSB first
//   out_dout : daisy-chain output of the receiver
// master = controller side, slave = receiver side.
// ---------------------------------------------------------------------------
interface max7219_receiver_if;

   logic in_sclk;
   logic in_cs;
   logic in_din;
   logic out_dout;

   modport master (
      output in_sclk,
      output in_cs,
      output in_din,
      input  out_dout
   );

   modport slave (
      input  in_sclk,
      input  in_cs,
      input  in_din,
      output out_dout
   );

endinterface

// File: rtl/max7219_receiver_codeb.sv
// ---------------------------------------------------------------------------
// max7219_codeb
// Combinational Code-B decoder for one digit.
//   digit : 4-bit digit code (0-9, '-', E, H, L, P, blank)
//   dp    : decimal point
//   segs  : {DP,A,B,C,D,E,F,G}
// ---------------------------------------------------------------------------
module max7219_codeb
   import max7219_pkg::*;
(
   input  logic [3:0] digit,
   input  logic       dp,
   output logic [7:0] segs
);

   assign segs = {dp, codeb_segs(digit)};

endmodule

// File: rtl/max7219_receiver.sv
// ---------------------------------------------------------------------------
// max7219_receiver
// MAX7219 LED-driver emulation. Receives 16-bit command words on the 3-wire
// bus, maintains the register file and produces the effective pixel matrix.
//   in_clk, in_rst   : system clock, asynchronous active-high reset
//   bus (slave)      : in_sclk / in_cs / in_din in, out_dout daisy-chain out
//   out_pixels       : effective pixels, digit k at [(k-1)*8 +: 8]
//   out_intensity    : intensity register
//   out_scan_limit   : scan-limit register
//   out_decode       : decode-mode register
//   out_power        : 1 = normal operation, 0 = shutdown
//   out_test         : display-test register
//   out_word_valid   : one-cycle pulse when a word is applied
//   out_word         : last applied word
//   out_frame_err    : one-cycle pulse when CS rises on a short frame
// ---------------------------------------------------------------------------
module max7219_receiver
   import max7219_pkg::*;
#(
   parameter int NUM_SEGS     = 8,
   parameter int LEDS_PER_SEG = 8,
   parameter int BUS_BITS     = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic                             in_clk,
   input  logic                             in_rst,
   max7219_receiver_if.slave                bus,
   output logic [LEDS_PER_SEG*NUM_SEGS-1:0] out_pixels,
   output logic [3:0]                       out_intensity,
   output logic [2:0]                       out_scan_limit,
   output logic [7:0]                       out_decode,
   output logic                             out_power,
   output logic                             out_test,
   output logic                             out_word_valid,
   output logic [BUS_BITS-1:0]              out_word,
   output logic                             out_frame_err
);

   localparam int CNT_W = $clog2(BUS_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUS_BITS);

   // ---------------- input synchronisers + edge detect ----------------
   // bit 2 = sclk, bit 1 = cs, bit 0 = din
   logic [2:0] sync_q [SYNC_STAGES];
   logic [1:0] edge_q;               // {sclk, cs} one sample behind sync output

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
         edge_q <= '0;
      end else begin
         sync_q[0] <= {bus.in_sclk, bus.in_cs, bus.in_din};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         edge_q <= sync_q[SYNC_STAGES-1][2:1];
      end
   end

   logic sclk_s, cs_s, din_s;
   logic sclk_rise, sclk_fall, cs_rise, cs_fall;

   assign sclk_s    = sync_q[SYNC_STAGES-1][2];
   assign cs_s      = sync_q[SYNC_STAGES-1][1];
   assign din_s     = sync_q[SYNC_STAGES-1][0];
   assign sclk_rise =  sclk_s & ~edge_q[1];
   assign sclk_fall = ~sclk_s &  edge_q[1];
   // Reset values of 0 mean a CS held low through reset never shows a fall.
   assign cs_rise   =  cs_s   & ~edge_q[0];
   assign cs_fall   = ~cs_s   &  edge_q[0];

   // ---------------- state machine ----------------
   t_rx_state state, state_next;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_after;
   logic [BUS_BITS-1:0] sr;
   logic shift_en, cnt_clear, apply_en, frame_err_en;

   // Inside Shift the frame is known to be open, so a sclk rise that lands in
   // the same sample as the CS rise still shifts and counts before the check.
   assign shift_en  = sclk_rise & ((state == Shift) | ~cs_s);
   assign cnt_after = (sclk_rise && state == Shift && cnt != CNT_FULL) ? cnt + 1'b1 : cnt;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) state <= Idle;
      else        state <= state_next;
   end

   always_comb begin
      state_next   = state;
      cnt_clear    = 1'b0;
      apply_en     = 1'b0;
      frame_err_en = 1'b0;
      case (state)
         Idle: begin
            if (cs_fall) begin
               cnt_clear  = 1'b1;
               state_next = Shift;
            end
         end
         Shift: begin
            if (cs_rise) begin
               if (cnt_after == CNT_FULL) begin
                  state_next = Apply;
               end else begin
                  frame_err_en = 1'b1;
                  state_next   = Idle;
               end
            end
         end
         Apply: begin
            apply_en   = 1'b1;
            state_next = Idle;
         end
         default: state_next = Idle;
      endcase
   end

   // ---------------- shift register, counter, daisy-chain ----------------
   logic dout_q;

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         sr     <= '0;
         cnt    <= '0;
         dout_q <= 1'b0;
      end else begin
         if (shift_en)  sr <= {sr[BUS_BITS-2:0], din_s};
         if (cnt_clear) cnt <= '0;
         else           cnt <= cnt_after;
         if (sclk_fall) dout_q <= sr[BUS_BITS-1];
      end
   end

   assign bus.out_dout = dout_q;

   // ---------------- register file ----------------
   logic [7:0] digits [NUM_SEGS];
   logic [3:0] addr;
   logic [7:0] data;

   assign addr = sr[11:8];
   assign data = sr[7:0];

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) begin
         for (int unsigned k = 0; k < NUM_SEGS; k++) digits[k] <= '0;
         out_intensity  <= '0;
         out_scan_limit <= '0;
         out_decode     <= '0;
         out_power      <= 1'b0;
         out_test       <= 1'b0;
         out_word       <= '0;
         out_word_valid <= 1'b0;
         out_frame_err  <= 1'b0;
      end else begin
         out_word_valid <= apply_en;
         out_frame_err  <= frame_err_en;
         if (apply_en) begin
            out_word <= sr;
            // Digit addresses beyond NUM_SEGS match no slot and fall through.
            for (int unsigned k = 0; k < NUM_SEGS; k++) begin
               if (addr == 4'(k + 1)) digits[k] <= data;
            end
            case (addr)
               ADDR_DECODE:    out_decode     <= data;
               ADDR_INTENSITY: out_intensity  <= data[3:0];
               ADDR_SCANLIMIT: out_scan_limit <= data[2:0];
               ADDR_SHUTDOWN:  out_power      <= data[0];
               ADDR_TEST:      out_test       <= data[0];
               default: ;
            endcase
         end
      end
   end

   // ---------------- effective pixels ----------------
   logic [LEDS_PER_SEG*NUM_SEGS-1:0] pixels_next;

   for (genvar g = 0; g < NUM_SEGS; g++) begin : g_digit
      localparam logic [3:0] IDX = 4'(g);
      logic [7:0] decoded;
      logic [7:0] row;

      max7219_codeb u_codeb (
         .digit (digits[g][3:0]),
         .dp    (digits[g][7]),
         .segs  (decoded)
      );

      always_comb begin
         row = '0;
         if (out_test)                           row = '1;
         else if (!out_power)                    row = '0;
         else if (IDX > {1'b0, out_scan_limit})  row = '0;
         else if (out_decode[g])                 row = decoded;
         else                                    row = digits[g];
      end

      assign pixels_next[g*LEDS_PER_SEG +: LEDS_PER_SEG] = row;
   end

   always_ff @(posedge in_clk or posedge in_rst) begin
      if (in_rst) out_pixels <= '0;
      else        out_pixels <= pixels_next;
   end

endmodule
